// File: rtl/poly_tomsg_ctrl.sv
// Kyber poly_tomsg sequencer: fetches 256 coefficients, compresses each to one bit
// and streams 32 packed message bytes. Optional range flag: POLYTOMSG_RANGE_CHECK_EN.
module poly_tomsg_ctrl #(
  parameter int KYBER_N = 256,
  parameter int KYBER_Q = 3329,
  parameter int COEFF_W = 12,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               iStart,
  output logic               oBusy,
  output logic               oDone,
  output logic               oCoeffRdEn,
  output logic [ADDR_W-1:0]  oCoeffAddr,
  input  logic [COEFF_W-1:0] iCoeffData,
  output logic [COEFF_W-1:0] oCsubqIn,
  input  logic [COEFF_W-1:0] iCsubqOut,
  output logic [7:0]         oMsgByte,
  output logic [4:0]         oMsgIdx,
  output logic               oMsgValid,
  input  logic               iMsgReady,
  output logic               oRangeErr
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LATCH = 3'd2;
  localparam logic [2:0] S_EVAL  = 3'd3;
  localparam logic [2:0] S_EMIT  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [ADDR_W-1:0]  LAST_IDX = ADDR_W'(KYBER_N - 1);
  localparam logic [COEFF_W+1:0] HALF_Q_W = (COEFF_W+2)'(KYBER_Q / 2);
  localparam logic [COEFF_W+1:0] Q_W      = (COEFF_W+2)'(KYBER_Q);
  localparam logic [COEFF_W+1:0] Q2_W     = (COEFF_W+2)'(2 * KYBER_Q);

  logic [2:0]         state_q, state_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [COEFF_W-1:0] coeff_q, coeff_d;
  logic [7:0]         shift_q, shift_d;
  logic [7:0]         msgByte_q, msgByte_d;
  logic [4:0]         msgIdx_q, msgIdx_d;
  logic [COEFF_W+1:0] scaled;
  logic               msgBit;

  // round(2x/Q) mod 2: 2x+Q/2 stays below 3Q for any COEFF_W-bit x, so the
  // quotient is 1 exactly when the scaled value lies in [Q, 2Q).
  assign scaled = {1'b0, iCsubqOut, 1'b0} + HALF_Q_W;
  assign msgBit = (scaled >= Q_W) && (scaled < Q2_W);

`ifdef POLYTOMSG_RANGE_CHECK_EN
  logic rangeErr_q, rangeErr_d;
  logic rangeHit;
  assign rangeHit  = (iCsubqOut >= COEFF_W'(KYBER_Q));
  assign oRangeErr = rangeErr_q;
`else
  assign oRangeErr = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    coeff_d   = coeff_q;
    shift_d   = shift_q;
    msgByte_d = msgByte_q;
    msgIdx_d  = msgIdx_q;
`ifdef POLYTOMSG_RANGE_CHECK_EN
    rangeErr_d = rangeErr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (iStart) begin
          idx_d   = '0;
          shift_d = '0;
`ifdef POLYTOMSG_RANGE_CHECK_EN
          rangeErr_d = 1'b0;
`endif
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        coeff_d = iCoeffData;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        shift_d[idx_q[2:0]] = msgBit;
`ifdef POLYTOMSG_RANGE_CHECK_EN
        if (rangeHit) rangeErr_d = 1'b1;
`endif
        if (idx_q[2:0] == 3'd7) begin
          msgByte_d = {msgBit, shift_q[6:0]};
          msgIdx_d  = idx_q[ADDR_W-1:3];
          state_d   = S_EMIT;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      // Holding here without issuing reads is what stalls the whole sequence.
      S_EMIT: begin
        if (iMsgReady) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            shift_d = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      coeff_q   <= '0;
      shift_q   <= '0;
      msgByte_q <= '0;
      msgIdx_q  <= '0;
`ifdef POLYTOMSG_RANGE_CHECK_EN
      rangeErr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      coeff_q   <= coeff_d;
      shift_q   <= shift_d;
      msgByte_q <= msgByte_d;
      msgIdx_q  <= msgIdx_d;
`ifdef POLYTOMSG_RANGE_CHECK_EN
      rangeErr_q <= rangeErr_d;
`endif
    end
  end

  assign oBusy      = (state_q == S_FETCH) || (state_q == S_LATCH) ||
                      (state_q == S_EVAL)  || (state_q == S_EMIT);
  assign oDone      = (state_q == S_DONE);
  assign oCoeffRdEn = (state_q == S_FETCH);
  assign oCoeffAddr = idx_q;
  assign oCsubqIn   = coeff_q;
  assign oMsgByte   = msgByte_q;
  assign oMsgIdx    = msgIdx_q;
  assign oMsgValid  = (state_q == S_EMIT);

endmodule

// File: tb/tb_poly_tomsg_ctrl.sv
// Scoreboard bench for poly_tomsg_ctrl: RAM and csubq models, random data and
// backpressure, expected bytes computed from the compression rule.
module tb_poly_tomsg_ctrl;

  localparam int N = 256;
  localparam int Q = 3329;

  typedef struct packed {
    logic [4:0] idx;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iStart = 1'b0;
  logic        oBusy, oDone, oCoeffRdEn, oMsgValid, oRangeErr;
  logic [7:0]  oCoeffAddr;
  logic [11:0] iCoeffData, oCsubqIn, iCsubqOut;
  logic [7:0]  oMsgByte;
  logic [4:0]  oMsgIdx;
  logic        iMsgReady = 1'b1;

  logic [11:0] mem [N];
  logic [11:0] ramData_q = '0;
  logic [7:0]  ramAddr_q = '0;
  logic        injectErr = 1'b0;

  int   assertions = 0;
  int   failures = 0;
  int   cyc = 0;
  int   startCyc = 0;
  int   stallCnt = 0;
  int   readyMode = 0;
  int   stallLeft = 0;
  logic expRangeErr = 1'b0;
  exp_t expQ[$];

  logic       prevPending = 1'b0;
  logic [7:0] prevByte = '0;
  logic [4:0] prevIdx = '0;

  poly_tomsg_ctrl dut (
    .clk(clk), .rst_n(rst_n), .iStart(iStart), .oBusy(oBusy), .oDone(oDone),
    .oCoeffRdEn(oCoeffRdEn), .oCoeffAddr(oCoeffAddr), .iCoeffData(iCoeffData),
    .oCsubqIn(oCsubqIn), .iCsubqOut(iCsubqOut), .oMsgByte(oMsgByte),
    .oMsgIdx(oMsgIdx), .oMsgValid(oMsgValid), .iMsgReady(iMsgReady),
    .oRangeErr(oRangeErr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (oCoeffRdEn) begin
      ramData_q <= mem[oCoeffAddr];
      ramAddr_q <= oCoeffAddr;
    end
  end
  assign iCoeffData = ramData_q;
  // csubq stub; the injected out-of-range value models a faulty reducer.
  assign iCsubqOut = (injectErr && ramAddr_q == 8'd10) ? 12'd3500 :
                     ((oCsubqIn >= 12'(Q)) ? oCsubqIn - 12'(Q) : oCsubqIn);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int coefValue(input int i);
    int v;
    if (injectErr && i == 10) return 3500;
    v = int'(mem[i]);
    return (v >= Q) ? v - Q : v;
  endfunction

  task automatic buildExpected();
    exp_t e;
    expQ.delete();
    for (int b = 0; b < 32; b++) begin
      e.idx  = 5'(b);
      e.data = '0;
      for (int j = 0; j < 8; j++)
        e.data[j] = ((((2 * coefValue(8*b + j)) + Q/2) / Q) % 2) == 1;
      expQ.push_back(e);
    end
`ifdef POLYTOMSG_RANGE_CHECK_EN
    expRangeErr = injectErr;
`else
    expRangeErr = 1'b0;
`endif
  endtask

  task automatic checkIdle();
    checkOutput("rstBusy", oBusy, 0);
    checkOutput("rstDone", oDone, 0);
    checkOutput("rstRdEn", oCoeffRdEn, 0);
    checkOutput("rstAddr", oCoeffAddr, 0);
    checkOutput("rstCsubqIn", oCsubqIn, 0);
    checkOutput("rstMsgByte", oMsgByte, 0);
    checkOutput("rstMsgIdx", oMsgIdx, 0);
    checkOutput("rstMsgValid", oMsgValid, 0);
    checkOutput("rstRangeErr", oRangeErr, 0);
  endtask

  task automatic startRun(input int mode);
    buildExpected();
    readyMode = mode;
    stallLeft = 10;
    @(posedge clk); #1;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    startCyc = cyc;
    checkOutput("fetchAfterStart", oCoeffRdEn, 1);
    checkOutput("busyAfterStart", oBusy, 1);
    checkOutput("rangeErrCleared", oRangeErr, 0);
  endtask

  task automatic applyStimulus(input int mode, input bit pulseInDone);
    startRun(mode);
    for (int t = 0; t < 3000 && !oDone; t++) begin
      @(posedge clk); #1;
    end
    checkOutput("doneSeen", oDone, 1);
    if (pulseInDone) iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    checkOutput("idleAfterDone", oBusy, 0);
    checkOutput("donePulseWidth", oDone, 0);
    @(posedge clk); #1;
    checkOutput("idleStays", oBusy, 0);
    readyMode = 0;
  endtask

  // Sink ready driver: 0 always ready, 1 random, 2 ten stalled valid cycles, 3 stall at byte 5.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        1: iMsgReady = 1'($urandom_range(0, 1));
        2: begin
          if (stallLeft > 0) begin
            iMsgReady = 1'b0;
            if (oMsgValid) stallLeft--;
          end else begin
            iMsgReady = 1'b1;
          end
        end
        3: iMsgReady = !(oMsgValid && oMsgIdx == 5'd5);
        default: iMsgReady = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake and checks hold, timing and done.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevPending = 1'b0;
        stallCnt = 0;
      end else begin
        if (iStart && !oBusy && !oDone) stallCnt = 0;
        if (prevPending) begin
          checkOutput("holdValid", oMsgValid, 1);
          checkOutput("holdByte", oMsgByte, prevByte);
          checkOutput("holdIdx", oMsgIdx, prevIdx);
        end
        if (oMsgValid) begin
          checkOutput("noReadInEmit", oCoeffRdEn, 0);
          if (!prevPending)
            checkOutput("byteTime", cyc, startCyc + 24 + 25 * int'(oMsgIdx) + stallCnt);
          if (iMsgReady) begin
            prevPending = 1'b0;
            checkOutput("scoreboardHasEntry", expQ.size() != 0, 1);
            if (expQ.size() != 0) begin
              e = expQ.pop_front();
              checkOutput("msgIdx", oMsgIdx, e.idx);
              checkOutput("msgByte", oMsgByte, e.data);
            end
          end else begin
            stallCnt++;
            prevPending = 1'b1;
            prevByte = oMsgByte;
            prevIdx = oMsgIdx;
          end
        end else begin
          prevPending = 1'b0;
        end
        if (oDone) begin
          checkOutput("doneTime", cyc, startCyc + 800 + stallCnt);
          checkOutput("allBytesSeen", expQ.size(), 0);
          checkOutput("rangeErrAtDone", oRangeErr, expRangeErr);
        end
        if (oBusy && !oMsgValid)
          checkOutput("rangeErrIdleOrHeld", oRangeErr == 1'b1 && !expRangeErr, 0);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdle();
    rst_n = 1'b1;

    for (int i = 0; i < N; i++) mem[i] = 12'd0;
    applyStimulus(0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 12'd1665;
    applyStimulus(0, 1'b1);

    for (int i = 0; i < N; i++) mem[i] = 12'd0;
    mem[0] = 12'd832;  mem[1] = 12'd833;  mem[2] = 12'd2496; mem[3] = 12'd2497;
    mem[4] = 12'd3328; mem[5] = 12'd0;    mem[6] = 12'd1664; mem[7] = 12'd3329;
    applyStimulus(0, 1'b0);

    for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
    applyStimulus(2, 1'b0);

    injectErr = 1'b1;
    for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
    applyStimulus(1, 1'b0);
    injectErr = 1'b0;

    // Reset while byte 5 is stalled, with start pulses while busy.
    for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
    startRun(3);
    repeat (40) @(posedge clk);
    #1;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    for (int t = 0; t < 500 && !(oMsgValid && oMsgIdx == 5'd5); t++) begin
      @(posedge clk); #1;
    end
    checkOutput("reachedByte5", oMsgValid && oMsgIdx == 5'd5, 1);
    repeat (3) @(posedge clk);
    #1;
    iStart = 1'b1;
    @(posedge clk); #1;
    iStart = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkIdle();
    rst_n = 1'b1;
    readyMode = 0;
    expQ.delete();
    @(posedge clk); #1;
    checkOutput("idleAfterReset", oBusy, 0);

    for (int i = 0; i < N; i++) mem[i] = 12'($urandom_range(0, 4095));
    applyStimulus(1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
